risc_controller: RTL and testbench
==================================

// Module: risc_controller
// PURPOSE
//  Sequencing control unit of the 8-bit RISC CPU. Steps an 8-phase Moore state machine, one phase per clock.
//  Decodes the 3-bit opcode and the accumulator-zero flag into bus, register-load and PC control strobes.
//  Sits between the instruction register/ALU (inputs) and the PC, IR, accumulator, memory and bus driver.
// PARAMETERS
//  none (opcode and state encodings are fixed constants from the shared package)
// PORTS
//  clk      input  1  system clock; all state changes on the rising edge
//  rst      input  1  asynchronous, active-low reset (0 = reset)
//  opcode   input  3  instruction opcode from IR
//  is_zero  input  1  accumulator == 0 flag from ALU
//  sel      output 1  address mux: 1 = PC, 0 = IR operand address
//  rd       output 1  memory read enable
//  ld_ir    output 1  load instruction register
//  halt     output 1  halt request to CPU top
//  inc_pc   output 1  increment program counter
//  ld_ac    output 1  load accumulator
//  ld_pc    output 1  load PC from IR operand
//  wr       output 1  memory write enable
//  data_e   output 1  drive accumulator onto data bus
// BEHAVIOUR
//  Opcodes: HLT=000 SKZ=001 ADD=010 AND=011 XOR=100 LDA=101 STO=110 JMP=111.
//  ALUOP = ADD|AND|XOR|LDA.
//  States, in order and wrapping: INST_ADDR, INST_FETCH, INST_LOAD, IDLE, OP_ADDR, OP_FETCH, ALU_OP, STORE.
//  The state advances unconditionally every rising clk; STORE -> INST_ADDR. One instruction = 8 cycles.
//  Outputs are combinational from the current state, opcode and is_zero (Moore plus opcode qualification).
//  Unlisted outputs are 0 in that state.
//   INST_ADDR : sel=1
//   INST_FETCH: sel=1 rd=1
//   INST_LOAD : sel=1 rd=1 ld_ir=1
//   IDLE      : sel=1 rd=1 ld_ir=1
//   OP_ADDR   : inc_pc=1, halt=(opcode==HLT)
//   OP_FETCH  : rd=ALUOP
//   ALU_OP    : rd=ALUOP, inc_pc=(SKZ && is_zero), ld_pc=JMP, data_e=STO
//   STORE     : rd=ALUOP, ld_ac=ALUOP, ld_pc=JMP, wr=STO, data_e=STO
//  Reset: rst=0 forces state=INST_ADDR immediately, regardless of clk.
//   Outputs during reset: sel=1, all others 0.
//   Reset asserted mid-instruction aborts the instruction.
//   The first rising clk after rst rises moves the state to INST_FETCH.
//  HLT: halt is asserted only during OP_ADDR. The controller keeps cycling; freezing the CPU is the top level's job.
//  SKZ with is_zero=0: no extra inc_pc in ALU_OP. is_zero is sampled combinationally in ALU_OP only.
//  opcode may change at any time. Outputs follow it combinationally in the qualified states only.
//  Unreachable state encodings recover to INST_ADDR on the next clk.
//  Outputs never show X for any known input combination.
// STRUCTURE
//  Shared package cpu_pkg holds the opcode localparams (HLT..JMP) and the 3-bit state encodings (INST_ADDR=0 .. STORE=7).
//  Single module: one sequential always block for the state register, one combinational output decode.
//  No sub-module.
// TESTING
//  1. rst=0 for 1 cycle, then release -> sel=1 and all else 0.
//     Sequence INST_ADDR..STORE repeats with period 8 clks.
//  2. opcode=HLT -> halt=1 in OP_ADDR only; inc_pc=1 in OP_ADDR; rd/ld_ac/wr/ld_pc stay 0 in phases 5-7.
//  3. opcode=SKZ: is_zero=1 -> inc_pc=1 in OP_ADDR and ALU_OP.
//     is_zero=0 -> inc_pc=1 in OP_ADDR only.
//  4. opcode=ADD (and LDA=101) -> rd=1 in OP_FETCH/ALU_OP/STORE; ld_ac=1 in STORE only; wr=0 throughout.
//  5. opcode=STO (110) -> data_e=1 in ALU_OP and STORE; wr=1 in STORE only; rd=0 and ld_ac=0 in phases 5-7.
//  6. opcode=JMP (111) -> ld_pc=1 in ALU_OP and STORE.
//     rst dropped mid-STORE -> state returns to INST_ADDR asynchronously.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared constants for the 8-bit RISC CPU: opcode values, controller phase
// encodings and a small opcode classification helper.
package cpu_pkg;

  localparam logic [2:0] HLT = 3'b000;
  localparam logic [2:0] SKZ = 3'b001;
  localparam logic [2:0] ADD = 3'b010;
  localparam logic [2:0] AND = 3'b011;
  localparam logic [2:0] XOR = 3'b100;
  localparam logic [2:0] LDA = 3'b101;
  localparam logic [2:0] STO = 3'b110;
  localparam logic [2:0] JMP = 3'b111;

  // Controller phases, one per clock, visited in this order and wrapping.
  typedef enum logic [2:0] {
    INST_ADDR  = 3'd0,
    INST_FETCH = 3'd1,
    INST_LOAD  = 3'd2,
    IDLE       = 3'd3,
    OP_ADDR    = 3'd4,
    OP_FETCH   = 3'd5,
    ALU_OP     = 3'd6,
    STORE      = 3'd7
  } state_t;

  // Instructions that read a memory operand and write the accumulator.
  function automatic logic is_aluop(input logic [2:0] op);
    return (op == ADD) || (op == AND) || (op == XOR) || (op == LDA);
  endfunction

endpackage

// File: rtl/risc_controller.sv
// Sequencing controller for the 8-bit RISC CPU. An 8-phase Moore machine
// steps once per clock; control strobes are decoded combinationally from the
// current phase, qualified by the opcode (and is_zero for SKZ).
// dbg_state mirrors the current phase for observation only.
module risc_controller
  import cpu_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] opcode,
  input  logic       is_zero,
  output logic       sel,
  output logic       rd,
  output logic       ld_ir,
  output logic       halt,
  output logic       inc_pc,
  output logic       ld_ac,
  output logic       ld_pc,
  output logic       wr,
  output logic       data_e,
  output logic [2:0] dbg_state
);

  state_t state_q;
  state_t state_d;
  logic   aluop;

  assign aluop     = is_aluop(opcode);
  assign dbg_state = state_q;

  // Phase register; an active-low reset aborts any instruction in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= INST_ADDR;
    else      state_q <= state_d;
  end

  // Unconditional advance through the eight phases, STORE wrapping to INST_ADDR.
  always_comb begin
    state_d = INST_ADDR;
    case (state_q)
      INST_ADDR:  state_d = INST_FETCH;
      INST_FETCH: state_d = INST_LOAD;
      INST_LOAD:  state_d = IDLE;
      IDLE:       state_d = OP_ADDR;
      OP_ADDR:    state_d = OP_FETCH;
      OP_FETCH:   state_d = ALU_OP;
      ALU_OP:     state_d = STORE;
      STORE:      state_d = INST_ADDR;
      default:    state_d = INST_ADDR;
    endcase
  end

  // Strobe decode: every output defaults low so only the listed ones fire.
  always_comb begin
    sel    = 1'b0;
    rd     = 1'b0;
    ld_ir  = 1'b0;
    halt   = 1'b0;
    inc_pc = 1'b0;
    ld_ac  = 1'b0;
    ld_pc  = 1'b0;
    wr     = 1'b0;
    data_e = 1'b0;
    case (state_q)
      INST_ADDR: begin
        sel = 1'b1;
      end
      INST_FETCH: begin
        sel = 1'b1;
        rd  = 1'b1;
      end
      INST_LOAD, IDLE: begin
        sel   = 1'b1;
        rd    = 1'b1;
        ld_ir = 1'b1;
      end
      OP_ADDR: begin
        inc_pc = 1'b1;
        halt   = (opcode == HLT);
      end
      OP_FETCH: begin
        rd = aluop;
      end
      ALU_OP: begin
        rd     = aluop;
        inc_pc = (opcode == SKZ) && is_zero;
        ld_pc  = (opcode == JMP);
        data_e = (opcode == STO);
      end
      STORE: begin
        rd     = aluop;
        ld_ac  = aluop;
        ld_pc  = (opcode == JMP);
        wr     = (opcode == STO);
        data_e = (opcode == STO);
      end
      default: begin
        sel = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_risc_controller.sv
// Directed bench for risc_controller. Each instruction is run for eight
// phases against a hand-written table of expected strobes, packed as
// {sel,rd,ld_ir,halt,inc_pc,ld_ac,ld_pc,wr,data_e}, with phase 0 in the MSBs.
module tb_risc_controller;

  logic       clk;
  logic       rst;
  logic [2:0] opcode;
  logic       is_zero;
  logic       sel, rd, ld_ir, halt, inc_pc, ld_ac, ld_pc, wr, data_e;
  logic [2:0] dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  // Common instruction-fetch phases 0..3.
  localparam logic [35:0] FETCH = {9'b100000000, 9'b110000000,
                                   9'b111000000, 9'b111000000};
  localparam logic [8:0]  P4_RUN = 9'b000010000;
  localparam logic [8:0]  P4_HLT = 9'b000110000;
  localparam logic [8:0]  ZERO9  = 9'b000000000;
  localparam logic [8:0]  RESET_OUT = 9'b100000000;

  risc_controller dut (
    .clk       (clk),
    .rst       (rst),
    .opcode    (opcode),
    .is_zero   (is_zero),
    .sel       (sel),
    .rd        (rd),
    .ld_ir     (ld_ir),
    .halt      (halt),
    .inc_pc    (inc_pc),
    .ld_ac     (ld_ac),
    .ld_pc     (ld_pc),
    .wr        (wr),
    .data_e    (data_e),
    .dbg_state (dbg_state)
  );

  // Clock: 10 ns period, first rising edge at 5 ns.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Safety bound so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish, got running want finished");
    $fatal(1, "timeout");
  end

  function automatic logic [8:0] outs();
    return {sel, rd, ld_ir, halt, inc_pc, ld_ac, ld_pc, wr, data_e};
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b want %b", tag, obs, exp);
    end
  endtask

  // Runs one instruction starting in phase 0 (1 ns after an edge or after
  // reset release) and ends 1 ns after the edge that re-enters phase 0.
  task automatic run_instr(input string name, input logic [2:0] op, input logic z,
                           input logic [71:0] exp);
    logic [8:0] e;
    opcode  = op;
    is_zero = z;
    for (int p = 0; p < 8; p++) begin
      e = exp[(7-p)*9 +: 9];
      #1;
      check($sformatf("%s state p%0d", name, p), {13'd0, dbg_state}, p[15:0]);
      check($sformatf("%s outs p%0d", name, p), {7'd0, outs()}, {7'd0, e});
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst     = 1'b0;
    opcode  = 3'b000;
    is_zero = 1'b0;

    // Reset held across a rising edge: phase 0 and sel only.
    #12;
    check("reset state", {13'd0, dbg_state}, 16'd0);
    check("reset outs", {7'd0, outs()}, {7'd0, RESET_OUT});
    @(negedge clk);
    rst = 1'b1;

    run_instr("hlt", 3'b000, 1'b0, {FETCH, P4_HLT, ZERO9, ZERO9, ZERO9});
    run_instr("skz_z1", 3'b001, 1'b1, {FETCH, P4_RUN, ZERO9, 9'b000010000, ZERO9});
    run_instr("skz_z0", 3'b001, 1'b0, {FETCH, P4_RUN, ZERO9, ZERO9, ZERO9});
    run_instr("add", 3'b010, 1'b1,
              {FETCH, P4_RUN, 9'b010000000, 9'b010000000, 9'b010001000});
    run_instr("and", 3'b011, 1'b0,
              {FETCH, P4_RUN, 9'b010000000, 9'b010000000, 9'b010001000});
    run_instr("xor", 3'b100, 1'b0,
              {FETCH, P4_RUN, 9'b010000000, 9'b010000000, 9'b010001000});
    run_instr("lda", 3'b101, 1'b0,
              {FETCH, P4_RUN, 9'b010000000, 9'b010000000, 9'b010001000});
    run_instr("sto", 3'b110, 1'b1,
              {FETCH, P4_RUN, ZERO9, 9'b000000001, 9'b000000011});
    run_instr("jmp", 3'b111, 1'b0,
              {FETCH, P4_RUN, ZERO9, 9'b000000100, 9'b000000100});

    // Opcode changes mid-phase: only qualified phases react.
    opcode = 3'b010;
    #1;
    check("opchg fetch p0", {7'd0, outs()}, {7'd0, RESET_OUT});
    repeat (6) @(posedge clk);
    #1;
    check("opchg alu add", {7'd0, outs()}, 16'b0000000_010000000);
    opcode = 3'b110;
    #1;
    check("opchg alu sto", {7'd0, outs()}, 16'b0000000_000000001);
    opcode = 3'b001;
    is_zero = 1'b1;
    #1;
    check("opchg alu skz", {7'd0, outs()}, 16'b0000000_000010000);

    // JMP, then reset dropped in the middle of STORE without a clock edge.
    opcode = 3'b111;
    is_zero = 1'b0;
    @(posedge clk);
    #1;
    check("store jmp state", {13'd0, dbg_state}, 16'd7);
    check("store jmp outs", {7'd0, outs()}, 16'b0000000_000000100);
    #2;
    rst = 1'b0;
    #1;
    check("async rst state", {13'd0, dbg_state}, 16'd0);
    check("async rst outs", {7'd0, outs()}, {7'd0, RESET_OUT});
    @(negedge clk);
    rst = 1'b1;
    run_instr("post_rst add", 3'b010, 1'b0,
              {FETCH, P4_RUN, 9'b010000000, 9'b010000000, 9'b010001000});

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
